// File: rtl/stoch_dec_pkg.sv
// ============================================================================
// Module  : stoch_dec_pkg
// Purpose : shared types, default widths and helpers for the stochastic decoder
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package stoch_dec_pkg;

  localparam int DEF_NWORD = 3;
  localparam int DEF_M     = 8;
  localparam int DEF_NCH   = 2**DEF_NWORD;
  localparam int CNT_W     = DEF_M + 1;
  localparam int IDX_W     = DEF_NWORD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Extract lane i from a flat count bus built with the default geometry.
  function automatic logic [CNT_W-1:0] lane_count(
    input logic [DEF_NCH*CNT_W-1:0] flat,
    input int unsigned              lane
  );
    return flat[lane*CNT_W +: CNT_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/stoch_argmax.sv
// ============================================================================
// Module  : stoch_argmax
// Purpose : combinational argmax tree over NCH values, ties go to lowest index
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stoch_argmax
  import stoch_dec_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int W   = CNT_W,
  parameter int IW  = IDX_W
) (
  input  logic [NCH*W-1:0] vals,
  output logic [IW-1:0]    idx
);

  // Heap-ordered tree: leaves at NCH..2*NCH-1, node k reduces children 2k, 2k+1.
  // The left child always covers lower indices, so it wins unless strictly beaten.
  always_comb begin : p_tree
    logic [W-1:0]  node_v [1:2*NCH-1];
    logic [IW-1:0] node_i [1:2*NCH-1];
    for (int i = 0; i < NCH; i++) begin
      node_v[NCH+i] = vals[i*W +: W];
      node_i[NCH+i] = IW'(i);
    end
    for (int k = NCH - 1; k >= 1; k--) begin
      if (node_v[2*k+1] > node_v[2*k]) begin
        node_v[k] = node_v[2*k+1];
        node_i[k] = node_i[2*k+1];
      end else begin
        node_v[k] = node_v[2*k];
        node_i[k] = node_i[2*k];
      end
    end
    idx = node_i[1];
  end

endmodule

`default_nettype wire

// File: rtl/stoch_decoder.sv
// ============================================================================
// Module  : stoch_decoder
// Purpose : per-lane ones counter over a 2**M window with argmax readout.
//           Optional early stop at THR enabled by STOCH_DEC_EARLY_STOP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stoch_decoder
  import stoch_dec_pkg::*;
#(
  parameter int NWORD = DEF_NWORD,
  parameter int M     = DEF_M,
  parameter int NCH   = 2**NWORD
`ifdef STOCH_DEC_EARLY_STOP_EN
  , parameter int THR = 2**(M-1)
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   inference,
  input  logic [NCH-1:0]         bits_in,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [NCH*(M+1)-1:0]   counts,
  output logic [NWORD-1:0]       winner
);

  localparam int CW = M + 1;

  state_e              state_q, state_d;
  logic [NCH*CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [M-1:0]        win_q, win_d;
  logic [NWORD-1:0]    winner_q, winner_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [NWORD-1:0]    argmax_idx;
  logic [NWORD-1:0]    end_winner;
  logic                win_end;

  always_comb begin
    cnt_inc = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_inc[i*CW +: CW] = cnt_q[i*CW +: CW] + {{M{1'b0}}, bits_in[i]};
    end
  end

  // Winner is taken from the counts that include the final counted cycle.
  stoch_argmax #(
    .NCH (NCH),
    .W   (CW),
    .IW  (NWORD)
  ) u_argmax (
    .vals (cnt_inc),
    .idx  (argmax_idx)
  );

`ifdef STOCH_DEC_EARLY_STOP_EN
  logic [NCH-1:0]   hit;
  logic [NWORD-1:0] hit_idx;

  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = (cnt_inc[i*CW +: CW] >= CW'(THR));
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = NWORD'(i);
    end
  end

  assign win_end    = (win_q == {M{1'b1}}) || (|hit);
  assign end_winner = (|hit) ? hit_idx : argmax_idx;
`else
  assign win_end    = (win_q == {M{1'b1}});
  assign end_winner = argmax_idx;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    winner_d = winner_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      win_d    = '0;
      winner_d = '0;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
    end else if (start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      win_d   = '0;
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else if (state_q == ST_RUN && inference) begin
      cnt_d = cnt_inc;
      win_d = win_q + M'(1);
      if (win_end) begin
        state_d  = ST_DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        valid_d  = 1'b1;
        winner_d = end_winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      winner_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      winner_q <= winner_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign valid  = valid_q;
  assign counts = cnt_q;
  assign winner = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_stoch_decoder.sv
// ============================================================================
// Module  : tb_stoch_decoder
// Purpose : directed and randomized checks of stoch_decoder against a
//           window-level reference model
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stoch_decoder;
  import stoch_dec_pkg::*;

  localparam int NCH = 8;
  localparam int CW  = 9;
  localparam int WIN = 256;
  localparam int THR = 128;
`ifdef STOCH_DEC_EARLY_STOP_EN
  localparam int ES = 1;
`else
  localparam int ES = 0;
`endif
  localparam int NEED = (ES != 0) ? THR : WIN;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              inference = 1'b0;
  logic [NCH-1:0]    bits_in = '0;
  logic              busy, done, valid;
  logic [NCH*CW-1:0] counts;
  logic [2:0]        winner;

  stoch_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .inference (inference),
    .bits_in   (bits_in),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .counts    (counts),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  // Reference model: window bookkeeping in plain integers.
  bit m_run, m_valid, m_done;
  int m_win, m_n;
  int m_cnt [NCH];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_argmax();
    int best = 0;
    for (int i = 1; i < NCH; i++) if (m_cnt[i] > m_cnt[best]) best = i;
    return best;
  endfunction

  function automatic logic [NCH*CW-1:0] m_packed();
    logic [NCH*CW-1:0] p = '0;
    for (int i = 0; i < NCH; i++) p[i*CW +: CW] = CW'(m_cnt[i]);
    return p;
  endfunction

  task automatic model_clear();
    m_run = 0; m_valid = 0; m_done = 0; m_win = 0; m_n = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input bit s, input bit ab, input bit inf, input logic [NCH-1:0] b);
    int early;
    m_done = 0;
    if (ab) begin
      model_clear();
    end else if (s) begin
      m_run = 1; m_valid = 0; m_n = 0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    end else if (m_run && inf) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] += int'(b[i]);
      m_n++;
      early = -1;
      for (int i = 0; i < NCH; i++) if (ES != 0 && early < 0 && m_cnt[i] >= THR) early = i;
      if (m_n == WIN || early >= 0) begin
        m_run = 0; m_done = 1; m_valid = 1; m_n = 0;
        m_win = (early >= 0) ? early : ref_argmax();
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output after the edge.
  task automatic cyc(input bit s, input bit ab, input bit inf, input logic [NCH-1:0] b);
    start = s; abort = ab; inference = inf; bits_in = b;
    model_edge(s, ab, inf, b);
    @(posedge clk);
    #1;
    if (done) ndone++;
    check("busy",   128'(busy),    128'(m_run));
    check("done",   128'(done),    128'(m_done));
    check("valid",  128'(valid),   128'(m_valid));
    check("winner", 128'(winner),  128'(m_win));
    check("counts", 128'(counts),  128'(m_packed()));
    start = 0; abort = 0;
  endtask

  function automatic logic [NCH-1:0] rnd_sparse();
    return NCH'($urandom & $urandom);
  endfunction

  initial begin
    logic [NCH-1:0] b;
    bit got;
    int t_done, kc, stalls, d0;
    logic [7:0] dens [NCH];

    model_clear();
    #12;
    check("rst_busy",   128'(busy),   128'(0));
    check("rst_valid",  128'(valid),  128'(0));
    check("rst_counts", 128'(counts), 128'(0));
    check("rst_winner", 128'(winner), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: random bits and enable, no start
    for (int t = 0; t < 20; t++) cyc(0, 0, 1'($urandom), NCH'($urandom));

    // Full window: lane 3 always, lane 5 on even cycles
    d0 = ndone;
    cyc(1, 0, 1, '1);
    for (int k = 0; k < WIN; k++) begin
      b = '0; b[3] = 1'b1; b[5] = (k % 2 == 0);
      cyc(0, 0, 1, b);
    end
    check("fw_done_pulses", 128'(ndone - d0), 128'(1));
    check("fw_lane3", 128'(lane_count(counts, 3)), 128'(NEED));
    check("fw_lane5", 128'(lane_count(counts, 5)), 128'(NEED / 2));
    check("fw_winner", 128'(winner), 128'(3));
    check("fw_valid", 128'(valid), 128'(1));
    for (int t = 0; t < 5; t++) cyc(0, 0, 1'($urandom), NCH'($urandom));

    // Stall: 40 interleaved cycles with inference low
    cyc(1, 0, 1, '0);
    got = 0; t_done = -1; kc = 0; stalls = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      bit inf;
      inf = !((t % 7 == 3) && stalls < 40);
      if (!inf) stalls++;
      b = '0; b[3] = 1'b1; b[5] = (kc % 2 == 0);
      cyc(0, 0, inf, inf ? b : NCH'($urandom));
      if (inf) kc++;
      if (done) begin got = 1; t_done = t; end
    end
    check("stall_done_seen", 128'(got), 128'(1));
    check("stall_done_cycle", 128'(t_done), 128'(NEED + stalls - 1));
    check("stall_lane3", 128'(lane_count(counts, 3)), 128'(NEED));
    check("stall_lane5", 128'(lane_count(counts, 5)), 128'(NEED / 2));
    check("stall_winner", 128'(winner), 128'(3));

    // Tie between lanes 2 and 6
    cyc(1, 0, 1, '0);
    for (int k = 0; k < WIN; k++) begin
      b = '0; b[2] = (k < 200 && k % 2 == 0); b[6] = b[2];
      cyc(0, 0, 1, b);
    end
    check("tie_lane2", 128'(lane_count(counts, 2)), 128'(100));
    check("tie_lane6", 128'(lane_count(counts, 6)), 128'(100));
    check("tie_winner", 128'(winner), 128'(2));

    // Start in DONE drops valid at the next edge
    cyc(1, 0, 1, '1);
    check("start_in_done_valid", 128'(valid), 128'(0));
    check("start_in_done_busy",  128'(busy),  128'(1));

    // Restart after 100 counted cycles
    for (int k = 0; k < 100; k++) cyc(0, 0, 1, rnd_sparse());
    cyc(1, 0, 1, NCH'($urandom));
    got = 0; kc = 0;
    for (int t = 0; t < 600 && !got; t++) begin
      bit inf;
      inf = ($urandom_range(0, 3) != 0);
      if (inf) kc++;
      cyc(0, 0, inf, rnd_sparse());
      if (done) got = 1;
    end
    check("restart_done_seen", 128'(got), 128'(1));
    check("restart_counted", 128'(kc), 128'(WIN));

    // Random windows with per-lane densities and random stalls
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < NCH; i++) dens[i] = 8'($urandom_range(0, 110));
      cyc(1, 0, 1'($urandom), NCH'($urandom));
      got = 0;
      for (int t = 0; t < 600 && !got; t++) begin
        for (int i = 0; i < NCH; i++) b[i] = ($urandom_range(0, 255) < 32'(dens[i]));
        cyc(0, 0, ($urandom_range(0, 3) != 0), b);
        if (done) got = 1;
      end
      check("rand_done_seen", 128'(got), 128'(1));
    end

    // Lane 4 all ones (ends at THR when early stop is built in)
    cyc(1, 0, 1, '0);
    got = 0; kc = 0;
    for (int t = 0; t < 300 && !got; t++) begin
      b = '0; b[4] = 1'b1;
      kc++;
      cyc(0, 0, 1, b);
      if (done) got = 1;
    end
    check("lane4_done_seen", 128'(got), 128'(1));
    check("lane4_counted", 128'(kc), 128'(NEED));
    check("lane4_count", 128'(lane_count(counts, 4)), 128'(NEED));
    check("lane4_winner", 128'(winner), 128'(4));

    // Abort in DONE clears the result
    cyc(0, 1, 1, '1);
    check("abort_done_valid",  128'(valid),  128'(0));
    check("abort_done_winner", 128'(winner), 128'(0));

    // Start and abort together in RUN: abort wins
    cyc(1, 0, 1, '0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 1, NCH'($urandom));
    cyc(1, 1, 1, '1);
    check("start_abort_busy",  128'(busy),  128'(0));
    check("start_abort_valid", 128'(valid), 128'(0));
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, '1);

    // Asynchronous reset mid-window
    cyc(1, 0, 1, '0);
    for (int k = 0; k < 50; k++) cyc(0, 0, 1, NCH'($urandom));
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check("arst_busy",   128'(busy),   128'(0));
    check("arst_done",   128'(done),   128'(0));
    check("arst_valid",  128'(valid),  128'(0));
    check("arst_counts", 128'(counts), 128'(0));
    check("arst_winner", 128'(winner), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cyc(0, 0, 1, NCH'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
